divert_buffer: RTL



---
 rtl/divert_buffer_pkg.sv | 24 ++
 rtl/divert_fifo.sv | 68 ++++++
 rtl/divert_buffer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/divert_buffer_pkg.sv
// Shared types for the divert buffer: AW id/user widths, transaction type
// encodings, the buffered entry layout and the release FSM states.
package divert_buffer_pkg;

  localparam int PID_WIDTH         = 4;
  localparam int PAWUSER_WIDTH     = 2;
  localparam int DIVERT_ADDR_WIDTH = 32;

  localparam logic [PAWUSER_WIDTH-1:0] PAWUSER_DIVERT = 2'b01;
  localparam logic [PAWUSER_WIDTH-1:0] PAWUSER_BLOCK  = 2'b10;

  typedef struct packed {
    logic [PID_WIDTH-1:0]         id;
    logic [DIVERT_ADDR_WIDTH-1:0] addr;
    logic [PAWUSER_WIDTH-1:0]     user;
  } divert_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RELEASE = 2'd1,
    ACK     = 2'd2
  } divert_state_t;

endpackage

// File: rtl/divert_fifo.sv
// Synchronous FIFO of divert entries; occupancy flags are registered from the
// next-state count so they never depend combinationally on the current handshake.
module divert_fifo
  import divert_buffer_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = divert_entry_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  entry_t                     wdata_i,
  input  logic                       pop_i,
  output entry_t                     rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, empty_q;

  // Explicit wrap keeps non-power-of-two depths correct.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/divert_buffer.sv
// Holds diverted AW requests and replays one per spec_release request.
// Optional stall watchdog with sticky timeout_err: define DIVERT_BUF_WATCHDOG_EN.
module divert_buffer
  import divert_buffer_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_awvalid,
  output logic                       in_awready,
  input  logic [PID_WIDTH-1:0]       in_awid,
  input  logic [ADDR_WIDTH-1:0]      in_awaddr,
  input  logic [PAWUSER_WIDTH-1:0]   in_awuser,
  input  logic                       spec_release,
  output logic                       release_ready,
  output logic                       out_awvalid,
  input  logic                       out_awready,
  output logic [PID_WIDTH-1:0]       out_awid,
  output logic [ADDR_WIDTH-1:0]      out_awaddr,
  output logic [PAWUSER_WIDTH-1:0]   out_awuser,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       underflow_err
`ifdef DIVERT_BUF_WATCHDOG_EN
  ,
  output logic                       timeout_err
`endif
);

  typedef struct packed {
    logic [PID_WIDTH-1:0]     id;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [PAWUSER_WIDTH-1:0] user;
  } entry_t;

  divert_state_t state_q, state_d;
  logic          underflow_q;
  logic          uf_set;
  logic          out_vld, rel_rdy;
  logic          push, pop;
  entry_t        wr_entry, head;

  assign in_awready = ~full;
  assign push       = in_awvalid & ~full;
  assign pop        = out_vld & out_awready;
  assign wr_entry   = '{id: in_awid, addr: in_awaddr, user: in_awuser};

  divert_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // ACK is a fixed one-cycle state, so a held spec_release cannot retrigger there.
  always_comb begin
    state_d = state_q;
    out_vld = 1'b0;
    rel_rdy = 1'b0;
    uf_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (spec_release) begin
          if (empty) begin
            state_d = ACK;
            uf_set  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        out_vld = 1'b1;
        if (out_awready) state_d = ACK;
      end
      ACK: begin
        rel_rdy = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      underflow_q <= underflow_q | uf_set;
    end
  end

  // Storage is not reset, so the head fields are masked outside RELEASE.
  assign out_awvalid   = out_vld;
  assign out_awid      = out_vld ? head.id   : '0;
  assign out_awaddr    = out_vld ? head.addr : '0;
  assign out_awuser    = out_vld ? head.user : '0;
  assign release_ready = rel_rdy;
  assign underflow_err = underflow_q;

`ifdef DIVERT_BUF_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q;

  // Saturates at the limit; only a completed handshake clears it.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (pop) begin
      wd_cnt_d = '0;
    end else if (out_vld && !out_awready && (wd_cnt_q != WD_W'(TIMEOUT_CYCLES))) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_q | (wd_cnt_q == WD_W'(TIMEOUT_CYCLES));
    end
  end

  assign timeout_err = timeout_q;
`endif

endmodule
